// File: rtl/cache_control_nway.sv
// N-way set-associative cache controller: hit/writeback/fetch/fill sequencing,
// per-set true-LRU ages, victim selection and saturating performance counters.
module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int SET_W = 3,
  parameter int CNT_W = 16,
  localparam int TAG_W = 12 - SET_W,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SETS  = 1 << SET_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [15:0]            mem_address,
  output logic                   mem_resp,
  input  logic [WAYS-1:0]        way_hit,
  input  logic [WAYS-1:0]        way_valid,
  input  logic [WAYS-1:0]        way_dirty,
  input  logic [WAYS*TAG_W-1:0]  way_tag,
  input  logic                   pmem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [15:0]            pmem_address,
  output logic [WAYS-1:0]        load_way,
  output logic                   write_type,
  output logic                   cache_in_mux_sel,
  output logic                   insert_mux_sel,
  output logic [WAY_W-1:0]       victim_way,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count,
  output logic [CNT_W-1:0]       wb_count,
  input  logic                   count_clear
);

  typedef enum logic [1:0] {S_HIT, S_WRITEBACK, S_FETCH, S_FILL} state_t;

  state_t           state, state_next;
  logic [WAY_W-1:0] age [SETS][WAYS];
  logic             post_fill;

  logic [SET_W-1:0] set_idx;
  logic             req, hit, hit_now;
  logic [WAY_W-1:0] hit_idx, victim_next;
  logic             victim_dirty;
  logic [TAG_W-1:0] victim_tag;
  logic             lru_upd;
  logic [WAY_W-1:0] lru_way;
  logic             hit_inc, miss_inc, wb_inc;

  assign set_idx      = mem_address[3+SET_W:4];
  assign req          = mem_read | mem_write;
  assign hit          = |way_hit;
  assign hit_now      = (state == S_HIT) && req && hit;
  assign victim_dirty = way_valid[victim_next] & way_dirty[victim_next];
  assign victim_tag   = way_tag[victim_way*TAG_W +: TAG_W];

  // Lowest-index hit way; way_hit is normally one-hot.
  always_comb begin
    hit_idx = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (way_hit[w]) hit_idx = WAY_W'(w);
  end

  // LRU way first, then overridden by the lowest-index invalid way if any.
  always_comb begin
    victim_next = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set_idx][w] == WAY_W'(WAYS-1)) victim_next = WAY_W'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (!way_valid[w]) victim_next = WAY_W'(w);
  end

  always_comb begin
    state_next       = state;
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = {mem_address[15:4], 4'h0};
    load_way         = '0;
    write_type       = 1'b0;
    cache_in_mux_sel = 1'b0;
    insert_mux_sel   = 1'b0;
    lru_upd          = 1'b0;
    lru_way          = hit_idx;
    case (state)
      S_HIT: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          lru_upd  = 1'b1;
          if (mem_write) begin
            load_way[hit_idx] = 1'b1;
            write_type        = 1'b1;
            cache_in_mux_sel  = 1'b1;
          end
        end else if (req) begin
          state_next = victim_dirty ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {victim_tag, set_idx, 4'h0};
        if (pmem_resp) state_next = S_FETCH;
      end
      S_FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_next = S_FILL;
      end
      S_FILL: begin
        load_way[victim_way] = 1'b1;
        insert_mux_sel       = 1'b1;
        write_type           = mem_write;
        cache_in_mux_sel     = mem_write;
        lru_upd              = 1'b1;
        lru_way              = victim_way;
        state_next           = S_HIT;
      end
      default: state_next = S_HIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HIT;
      victim_way <= '0;
      post_fill  <= 1'b0;
    end else begin
      state     <= state_next;
      post_fill <= (state == S_FILL);
      if (state == S_HIT && req && !hit) victim_way <= victim_next;
    end
  end

  // Accessed way becomes MRU; only ways younger than it age by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else if (lru_upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == lru_way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < age[set_idx][lru_way])
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end

  // The replayed request right after a fill was already counted as a miss.
  assign hit_inc  = hit_now && !post_fill;
  assign miss_inc = (state == S_FILL);
  assign wb_inc   = (state == S_WRITEBACK) && pmem_resp;

  always_ff @(posedge clk) begin
    if (reset || count_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_inc  && hit_count  != '1) hit_count  <= hit_count  + 1'b1;
      if (miss_inc && miss_count != '1) miss_count <= miss_count + 1'b1;
      if (wb_inc   && wb_count   != '1) wb_count   <= wb_count   + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4, SET_W=3, CNT_W=4).
module tb_cache_control_nway;
  localparam int WAYS = 4, SET_W = 3, CNT_W = 4, TAG_W = 12 - SET_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mem_read, mem_write;
  logic [15:0]           mem_address;
  logic                  mem_resp;
  logic [WAYS-1:0]       way_hit, way_valid, way_dirty;
  logic [WAYS*TAG_W-1:0] way_tag;
  logic                  pmem_resp, pmem_read, pmem_write;
  logic [15:0]           pmem_address;
  logic [WAYS-1:0]       load_way;
  logic                  write_type, cache_in_mux_sel, insert_mux_sel;
  logic [1:0]            victim_way;
  logic [CNT_W-1:0]      hit_count, miss_count, wb_count;
  logic                  count_clear;

  int n_checks = 0;
  int n_errors = 0;

  cache_control_nway #(.WAYS(WAYS), .SET_W(SET_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_resp(mem_resp),
    .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty), .way_tag(way_tag),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .load_way(load_way), .write_type(write_type), .cache_in_mux_sel(cache_in_mux_sel),
    .insert_mux_sel(insert_mux_sel), .victim_way(victim_way),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
    .count_clear(count_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    way_hit     = '0;
    pmem_resp   = 1'b0;
    count_clear = 1'b0;
  endtask

  task automatic do_hit(input logic [3:0] h);
    way_hit  = h;
    mem_read = 1'b1;
    #1;
    check("hit_resp", mem_resp, 1);
    step;
    idle_req;
  endtask

  // Called one cycle into FETCH with the request still held; finishes with the replayed hit.
  task automatic fetch_fill(input logic [3:0] exp_load, input logic exp_wt);
    check("fetch_rd", pmem_read, 1);
    check("fetch_no_wr", pmem_write, 0);
    pmem_resp = 1'b1;
    step;
    pmem_resp = 1'b0;
    #1;
    check("fill_load", load_way, exp_load);
    check("fill_insert", insert_mux_sel, 1);
    check("fill_wt", write_type, exp_wt);
    check("fill_cmux", cache_in_mux_sel, exp_wt);
    check("fill_no_pmem", {pmem_read, pmem_write}, 0);
    step;
    way_hit = exp_load;
    #1;
    check("replay_resp", mem_resp, 1);
    step;
    idle_req;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_req;
    mem_address = '0;
    way_valid = '0;
    way_dirty = '0;
    way_tag = '0;
    step;
    step;
    check("rst_hit", hit_count, 0);
    check("rst_miss", miss_count, 0);
    check("rst_wb", wb_count, 0);
    check("rst_victim", victim_way, 0);
    check("rst_pmem", {pmem_read, pmem_write}, 0);
    reset = 1'b0;

    // Read miss with all ways invalid
    mem_address = 16'h0010;
    mem_read = 1'b1;
    #1;
    check("miss_no_resp", mem_resp, 0);
    step;
    check("miss_victim", victim_way, 0);
    check("fetch_addr", pmem_address, 16'h0010);
    step;
    check("fetch_hold", pmem_read, 1);
    way_valid = 4'b0001;
    fetch_fill(4'b0001, 1'b0);
    check("miss1_cnt", miss_count, 1);
    check("miss1_hit", hit_count, 0);

    // LRU victim selection in set 2
    mem_address = 16'h0020;
    way_valid = 4'hF;
    do_hit(4'b0001);
    do_hit(4'b0010);
    do_hit(4'b0100);
    do_hit(4'b1000);
    check("lru_hits", hit_count, 4);
    mem_read = 1'b1;
    step;
    check("lru_victim0", victim_way, 0);
    fetch_fill(4'b0001, 1'b0);
    check("miss2_cnt", miss_count, 2);
    check("replay_uncounted", hit_count, 4);
    do_hit(4'b0010);
    check("hit5", hit_count, 5);
    mem_read = 1'b1;
    step;
    check("lru_victim2", victim_way, 2);
    fetch_fill(4'b0100, 1'b0);
    check("miss3_cnt", miss_count, 3);

    // Write hit on way 3 with read also asserted
    mem_read = 1'b1;
    mem_write = 1'b1;
    way_hit = 4'b1000;
    #1;
    check("wr_hit_resp", mem_resp, 1);
    check("wr_hit_load", load_way, 4'b1000);
    check("wr_hit_wt", write_type, 1);
    check("wr_hit_cmux", cache_in_mux_sel, 1);
    check("wr_hit_insert", insert_mux_sel, 0);
    step;
    idle_req;
    check("wr_hit_cnt", hit_count, 6);
    mem_read = 1'b1;
    step;
    check("way3_mru_victim", victim_way, 0);
    fetch_fill(4'b0001, 1'b0);
    check("miss4_cnt", miss_count, 4);

    // Write miss with dirty victim in set 5
    mem_address = 16'h3456;
    way_valid = 4'hF;
    way_dirty = 4'b1000;
    way_tag = {9'h1A5, 9'h011, 9'h022, 9'h033};
    mem_write = 1'b1;
    step;
    check("wb_victim", victim_way, 3);
    check("wb_strobe", {pmem_read, pmem_write}, 2'b01);
    check("wb_addr", pmem_address, 16'hD2D0);
    step;
    check("wb_hold", pmem_write, 1);
    pmem_resp = 1'b1;
    step;
    pmem_resp = 1'b0;
    #1;
    check("wb_cnt", wb_count, 1);
    check("wb_fetch_addr", pmem_address, 16'h3450);
    check("wb_fetch_no_wr", pmem_write, 0);
    fetch_fill(4'b1000, 1'b1);
    check("miss5_cnt", miss_count, 5);
    check("hit_after_wb", hit_count, 6);

    // Reset during FETCH
    mem_address = 16'h0040;
    way_valid = 4'b0011;
    way_dirty = '0;
    mem_read = 1'b1;
    step;
    check("pre_rst_victim", victim_way, 2);
    check("pre_rst_fetch", pmem_read, 1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    idle_req;
    #1;
    check("rst_fetch_pmem", {pmem_read, pmem_write}, 0);
    check("rst_fetch_hit", hit_count, 0);
    check("rst_fetch_miss", miss_count, 0);
    check("rst_fetch_wb", wb_count, 0);
    check("rst_fetch_victim", victim_way, 0);
    way_valid = 4'hF;
    do_hit(4'b0001);
    check("post_rst_hit", hit_count, 1);

    // Saturation and clear priority
    for (int i = 0; i < 14; i++) do_hit(4'b0001);
    check("hit_15", hit_count, 15);
    do_hit(4'b0001);
    check("hit_sat", hit_count, 15);
    mem_read = 1'b1;
    way_hit = 4'b0001;
    count_clear = 1'b1;
    step;
    idle_req;
    check("clear_prio", hit_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
